// File: rtl/kfps2kb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : kfps2kb_pkg                                                |
// | Description : Shared types and constants for the PS/2 host command       |
// |               sequencer: FSM state encoding, result codes, response      |
// |               bytes and the frame builder (odd parity + data byte).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package kfps2kb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    TX_BITS   = 3'd3,
    LINE_ACK  = 3'd4,
    WAIT_RESP = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_NACK    = 2'd2;
  localparam logic [1:0] ST_LINE    = 2'd3;

  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;

  // Bits shifted out after the start bit: data LSB first, then odd parity.
  function automatic logic [8:0] frame_of(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kfps2kb_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : kfps2kb_line_sync                                          |
// | Description : Two-flop synchronisers for the raw PS/2 clock and data     |
// |               lines plus a one-cycle pulse on each synchronised clock    |
// |               falling edge.                                              |
// | Ports       : clock, reset (async, active-high), device_clock,           |
// |               device_data (raw lines in), data_sync (synced data out),   |
// |               clock_fall (falling-edge pulse out)                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module kfps2kb_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic device_clock,
  input  logic device_data,
  output logic data_sync,
  output logic clock_fall
);

  logic [1:0] clock_meta;
  logic [1:0] data_meta;
  logic       clock_prev;

  // Idle PS/2 lines are pulled high, so the flops reset to 1 to avoid a
  // phantom falling edge straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clock_meta <= 2'b11;
      data_meta  <= 2'b11;
      clock_prev <= 1'b1;
    end else begin
      clock_meta <= {clock_meta[0], device_clock};
      data_meta  <= {data_meta[0], device_data};
      clock_prev <= clock_meta[1];
    end
  end

  assign data_sync  = data_meta[1];
  assign clock_fall = clock_prev & ~clock_meta[1];

endmodule
`default_nettype wire

// File: rtl/kfps2kb_host_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : kfps2kb_host_command_sequencer                             |
// | Description : Sends one- or two-byte host-to-keyboard commands over the  |
// |               PS/2 lines (open-drain enables only), checks the line ACK  |
// |               and the keyboard response byte (FA ok / FE resend), and    |
// |               masks the keycode path while a transaction is in flight.   |
// | Ports       : clock, reset (async, active-high); device_clock/data raw   |
// |               lines in, device_clock_oe/data_oe pull-low enables out;    |
// |               cmd_valid/cmd_byte/cmd_has_arg/cmd_arg in, cmd_ready out;  |
// |               rx_byte/rx_strobe/rx_error from shift register in,         |
// |               rx_mask out; done pulse and 2-bit status out.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module kfps2kb_host_command_sequencer
  import kfps2kb_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned BIT_TIMEOUT    = 750000,
  parameter int unsigned RESP_TIMEOUT   = 1000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_strobe,
  input  logic       rx_error,
  output logic       rx_mask,
  output logic       done,
  output logic [1:0] status
);

  localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] BIT_LIMIT    = 32'(BIT_TIMEOUT);
  localparam logic [31:0] RESP_LIMIT   = 32'(RESP_TIMEOUT);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  logic data_sync;
  logic clock_fall;

  kfps2kb_line_sync u_line_sync (
    .clock        (clock),
    .reset        (reset),
    .device_clock (device_clock),
    .device_data  (device_data),
    .data_sync    (data_sync),
    .clock_fall   (clock_fall)
  );

  state_t      state, next_state;
  logic [31:0] timer, next_timer;
  logic [3:0]  bit_cnt, next_bit_cnt;
  logic [8:0]  shift, next_shift;
  logic        data_oe_r, next_data_oe;
  logic        byte_sel, next_byte_sel;   // 0 = command byte, 1 = argument
  logic [3:0]  retry, next_retry;
  logic [1:0]  status_r, next_status;
  logic [7:0]  cmd_r, next_cmd;
  logic [7:0]  arg_r, next_arg;
  logic        has_arg_r, next_has_arg;
  logic        start_bit;

  // Start bit goes out on the final inhibit cycle so data is already low
  // when the clock line is released.
  assign start_bit = (state == INHIBIT) && (timer >= INHIBIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data_oe_r <= 1'b0;
      byte_sel  <= 1'b0;
      retry     <= '0;
      status_r  <= ST_OK;
      cmd_r     <= '0;
      arg_r     <= '0;
      has_arg_r <= 1'b0;
    end else begin
      state     <= next_state;
      timer     <= next_timer;
      bit_cnt   <= next_bit_cnt;
      shift     <= next_shift;
      data_oe_r <= next_data_oe;
      byte_sel  <= next_byte_sel;
      retry     <= next_retry;
      status_r  <= next_status;
      cmd_r     <= next_cmd;
      arg_r     <= next_arg;
      has_arg_r <= next_has_arg;
    end
  end

  always_comb begin
    next_state    = state;
    next_timer    = (timer == '1) ? timer : timer + 32'd1;
    next_bit_cnt  = bit_cnt;
    next_shift    = shift;
    next_data_oe  = data_oe_r;
    next_byte_sel = byte_sel;
    next_retry    = retry;
    next_status   = status_r;
    next_cmd      = cmd_r;
    next_arg      = arg_r;
    next_has_arg  = has_arg_r;

    case (state)
      IDLE: begin
        next_data_oe = 1'b0;
        if (cmd_valid) begin
          next_cmd      = cmd_byte;
          next_arg      = cmd_arg;
          next_has_arg  = cmd_has_arg;
          next_retry    = '0;
          next_byte_sel = 1'b0;
          next_timer    = '0;
          next_state    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (start_bit) begin
          next_data_oe = 1'b1;
          next_state   = START;
        end
      end
      START: begin
        next_shift   = frame_of(byte_sel ? arg_r : cmd_r);
        next_bit_cnt = '0;
        next_timer   = '0;
        next_state   = TX_BITS;
      end
      TX_BITS: begin
        if (timer >= BIT_LIMIT) begin
          next_data_oe = 1'b0;
          next_status  = ST_TIMEOUT;
          next_state   = DONE;
        end else if (clock_fall) begin
          if (bit_cnt < 4'd9) begin
            next_data_oe = ~shift[bit_cnt];
            next_bit_cnt = bit_cnt + 4'd1;
          end else begin
            next_data_oe = 1'b0;   // stop bit: release data
            next_state   = LINE_ACK;
          end
        end
      end
      LINE_ACK: begin
        if (timer >= BIT_LIMIT) begin
          next_status = ST_TIMEOUT;
          next_state  = DONE;
        end else if (clock_fall) begin
          if (!data_sync) begin
            next_timer = '0;
            next_state = WAIT_RESP;
          end else begin
            next_status = ST_LINE;
            next_state  = DONE;
          end
        end
      end
      WAIT_RESP: begin
        if (rx_error || (rx_strobe && rx_byte == RESEND)) begin
          if (retry < RETRY_LIMIT) begin
            next_retry = retry + 4'd1;
            next_timer = '0;
            next_state = INHIBIT;
          end else begin
            next_status = ST_NACK;
            next_state  = DONE;
          end
        end else if (rx_strobe && rx_byte == ACK) begin
          if (!byte_sel && has_arg_r) begin
            next_byte_sel = 1'b1;
            next_retry    = '0;
            next_timer    = '0;
            next_state    = INHIBIT;
          end else begin
            next_status = ST_OK;
            next_state  = DONE;
          end
        end else if (rx_strobe) begin
          next_status = ST_NACK;
          next_state  = DONE;
        end else if (timer >= RESP_LIMIT) begin
          next_status = ST_TIMEOUT;
          next_state  = DONE;
        end
      end
      DONE: begin
        next_data_oe = 1'b0;
        next_state   = IDLE;
      end
      default: begin
        next_data_oe = 1'b0;
        next_state   = IDLE;
      end
    endcase
  end

  assign device_clock_oe = (state == INHIBIT);
  assign device_data_oe  = data_oe_r | start_bit;
  assign cmd_ready       = (state == IDLE);
  // Mask stays up through DONE so an FA strobe arriving late is still hidden.
  assign rx_mask         = (state != IDLE);
  assign done            = (state == DONE);
  assign status          = status_r;

endmodule
`default_nettype wire

// File: tb/tb_kfps2kb_host_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_kfps2kb_host_command_sequencer                          |
// | Description : Scoreboard bench: a PS/2 keyboard model clocks in frames   |
// |               and answers FA/FE; expected frames and status codes are    |
// |               queued by the stimulus and popped by the model / a done    |
// |               monitor.                                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_kfps2kb_host_command_sequencer;

  localparam int INH = 20;
  localparam int BT  = 1500;
  localparam int RT  = 1500;
  localparam int H   = 8;

  localparam int A_FA     = 0;
  localparam int A_FE     = 1;
  localparam int A_SILENT = 2;
  localparam int A_NOACK  = 3;
  localparam int A_RESET  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clk_drv, data_drv;
  logic       clock_oe, data_oe;
  logic       cmd_valid;
  logic [7:0] cmd_byte, cmd_arg;
  logic       cmd_has_arg, cmd_ready;
  logic       m_strobe, s_strobe;
  logic [7:0] m_byte, s_byte;
  logic       rx_error, rx_mask, done;
  logic [1:0] status;
  logic       mid_flag;

  wire        device_clock = ~clock_oe & clk_drv;
  wire        device_data  = ~data_oe & data_drv;
  wire        rx_strobe    = m_strobe | s_strobe;
  wire  [7:0] rx_byte      = m_strobe ? m_byte : s_byte;
  wire        irq          = rx_strobe & ~rx_mask;

  always #5 clock = ~clock;

  kfps2kb_host_command_sequencer #(
    .INHIBIT_CYCLES (INH),
    .BIT_TIMEOUT    (BT),
    .RESP_TIMEOUT   (RT),
    .MAX_RETRY      (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .device_clock    (device_clock),
    .device_data     (device_data),
    .device_clock_oe (clock_oe),
    .device_data_oe  (data_oe),
    .cmd_valid       (cmd_valid),
    .cmd_byte        (cmd_byte),
    .cmd_has_arg     (cmd_has_arg),
    .cmd_arg         (cmd_arg),
    .cmd_ready       (cmd_ready),
    .rx_byte         (rx_byte),
    .rx_strobe       (rx_strobe),
    .rx_error        (rx_error),
    .rx_mask         (rx_mask),
    .done            (done),
    .status          (status)
  );

  int checks = 0;
  int passed = 0;
  int done_count = 0;

  logic [8:0] exp_frames[$];
  int         actions[$];
  logic [1:0] exp_status[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_ok(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Done monitor: every done pulse must match the next queued status.
  always @(negedge clock) begin
    if (!reset && done === 1'b1) begin
      done_count++;
      if (exp_status.size() == 0) begin
        check_ok("unexpected_done", 1'b0, 1, 0);
      end else begin
        check_eq("status", {30'd0, status}, {30'd0, exp_status.pop_front()});
      end
      check_eq("oe_at_done", {30'd0, clock_oe, data_oe}, 32'd0);
      check_eq("mask_at_done", {31'd0, rx_mask}, 32'd1);
    end
  end

  // Keyboard model: clocks in each requested frame and answers per action.
  initial begin
    int         a;
    int         dc0;
    logic [8:0] f;
    logic [8:0] rx;
    logic       stop;
    bit         aborted;
    clk_drv  = 1'b1;
    data_drv = 1'b1;
    m_strobe = 1'b0;
    m_byte   = 8'h00;
    mid_flag = 1'b0;
    forever begin
      @(negedge clock);
      if (clock_oe !== 1'b1) continue;
      while (clock_oe === 1'b1) @(negedge clock);
      if (reset) continue;
      if (actions.size() == 0) begin
        check_ok("unexpected_frame", 1'b0, 1, 0);
        continue;
      end
      a   = actions.pop_front();
      f   = exp_frames.pop_front();
      dc0 = done_count;
      check_eq("start_bit", {31'd0, data_oe}, 32'd1);
      if (a == A_SILENT) continue;
      repeat (H) @(negedge clock);
      aborted = 1'b0;
      rx      = '0;
      stop    = 1'b0;
      for (int e = 1; e <= 11; e++) begin
        if (e == 11 && a != A_NOACK) begin
          data_drv = 1'b0;
          repeat (2) @(negedge clock);
        end
        clk_drv = 1'b0;
        repeat (H) @(negedge clock);
        if (e == 5 && a == A_RESET) begin
          mid_flag = 1'b1;
          while (mid_flag) @(negedge clock);
          clk_drv = 1'b1;
          aborted = 1'b1;
          break;
        end
        if (e <= 9) rx[e-1] = device_data;
        else if (e == 10) stop = device_data;
        clk_drv = 1'b1;
        repeat (H) @(negedge clock);
        if (e == 11) data_drv = 1'b1;
      end
      if (aborted) continue;
      check_eq("frame", {23'd0, rx}, {23'd0, f});
      check_eq("stop_bit", {31'd0, stop}, 32'd1);
      if (a == A_NOACK) check_ok("line_nack_prompt", done_count == dc0 + 1, done_count - dc0, 1);
      if (a == A_FA || a == A_FE) begin
        repeat (4) @(negedge clock);
        m_byte   = (a == A_FA) ? 8'hFA : 8'hFE;
        m_strobe = 1'b1;
        #1;
        check_eq("rx_mask_resp", {31'd0, rx_mask}, 32'd1);
        check_eq("irq_masked", {31'd0, irq}, 32'd0);
        @(negedge clock);
        m_strobe = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [7:0] b, input logic has, input logic [7:0] arg,
                         input logic [1:0] st, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    check_eq("ready_before", {31'd0, cmd_ready}, 32'd1);
    exp_status.push_back(st);
    cmd_byte    = b;
    cmd_has_arg = has;
    cmd_arg     = arg;
    cmd_valid   = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    check_eq("ready_busy", {31'd0, cmd_ready}, 32'd0);
    // A request while busy must be ignored (no extra frame or done).
    cmd_byte  = 8'h55;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clock);
      if (clock_oe) lat = 0;
      else lat++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check_ok("done_seen", got, int'(got), 1);
    @(negedge clock);
    check_eq("ready_after", {31'd0, cmd_ready}, 32'd1);
    check_eq("mask_after", {31'd0, rx_mask}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  got;
    cmd_valid   = 1'b0;
    cmd_byte    = 8'h00;
    cmd_has_arg = 1'b0;
    cmd_arg     = 8'h00;
    s_strobe    = 1'b0;
    s_byte      = 8'h00;
    rx_error    = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_mask", {31'd0, rx_mask}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_status", {30'd0, status}, 32'd0);
    check_eq("rst_oe", {30'd0, clock_oe, data_oe}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Keycode strobe in IDLE passes through.
    s_byte   = 8'h1C;
    s_strobe = 1'b1;
    #1;
    check_eq("idle_mask", {31'd0, rx_mask}, 32'd0);
    check_eq("idle_irq", {31'd0, irq}, 32'd1);
    @(negedge clock);
    s_strobe = 1'b0;

    // ED + 02, both acknowledged.
    actions.push_back(A_FA); exp_frames.push_back(9'h1ED);
    actions.push_back(A_FA); exp_frames.push_back(9'h002);
    run_cmd(8'hED, 1'b1, 8'h02, 2'd0, lat);

    // FF: one resend then ACK.
    actions.push_back(A_FE); exp_frames.push_back(9'h1FF);
    actions.push_back(A_FA); exp_frames.push_back(9'h1FF);
    run_cmd(8'hFF, 1'b0, 8'h00, 2'd0, lat);

    // FF: resend three times -> NACK after two retries.
    for (int i = 0; i < 3; i++) begin
      actions.push_back(A_FE);
      exp_frames.push_back(9'h1FF);
    end
    run_cmd(8'hFF, 1'b0, 8'h00, 2'd2, lat);
    repeat (5) @(negedge clock);
    check_eq("status_held", {30'd0, status}, 32'd2);

    // F4: keyboard never clocks -> timeout.
    actions.push_back(A_SILENT); exp_frames.push_back(9'h0F4);
    run_cmd(8'hF4, 1'b0, 8'h00, 2'd1, lat);
    check_ok("timeout_latency", lat >= BT && lat <= BT + 6, lat, BT + 3);

    // F5: no line-ACK -> line error without waiting for a response.
    actions.push_back(A_NOACK); exp_frames.push_back(9'h1F5);
    run_cmd(8'hF5, 1'b0, 8'h00, 2'd3, lat);

    // F4 with reset at bit 4: lines released at once, no done.
    actions.push_back(A_RESET); exp_frames.push_back(9'h0F4);
    cmd_byte    = 8'hF4;
    cmd_has_arg = 1'b0;
    cmd_valid   = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clock);
      if (mid_flag) begin
        got = 1'b1;
        break;
      end
    end
    check_ok("mid_frame_reached", got, int'(got), 1);
    reset = 1'b1;
    #1;
    check_eq("reset_oe", {30'd0, clock_oe, data_oe}, 32'd0);
    check_eq("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("reset_no_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    mid_flag = 1'b0;
    repeat (20) @(negedge clock);

    // Next command after the reset completes normally.
    actions.push_back(A_FA); exp_frames.push_back(9'h0F4);
    run_cmd(8'hF4, 1'b0, 8'h00, 2'd0, lat);

    repeat (10) @(negedge clock);
    check_eq("actions_drained", actions.size(), 32'd0);
    check_eq("status_drained", exp_status.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
